// File: rtl/ex_mem_latch.sv
// ---------------------------------------------------------------------------
// ex_mem_latch -- EX/MEM pipeline register.
//
// Captures the ALU result, flags, destination/control bits and store data of
// the instruction leaving EX, applies stall (en=0) and flush, and turns a
// signed-overflow trap into a squashed instruction that still occupies MEM
// with its exception flag raised. It also exports the MEM-stage forwarding
// view and keeps a count of valid instructions captured.
//
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   en, flush                 advance enable / squash (flush wins)
//   ex_valid                  EX holds a real instruction
//   ex_out, ex_negative,
//   ex_overflow, ex_zero      ALU result and flags
//   ex_ovf_trap_en            instruction traps on signed overflow
//   ex_wsel, ex_regwen,
//   ex_memren, ex_memwen      destination and controls
//   ex_store_data             forwarded rt value for stores
//   mem_*                     latched instruction state
//   ovf_exception             MEM instruction trapped on overflow
//   fwd_en/fwd_wsel/fwd_data  forwardable ALU result in MEM
//   load_pending              MEM holds a load to a nonzero register
//   captured_count            valid instructions captured (wraps)
// ---------------------------------------------------------------------------
module ex_mem_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_out,
    input  logic              ex_negative,
    input  logic              ex_overflow,
    input  logic              ex_zero,
    input  logic              ex_ovf_trap_en,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic              ex_regwen,
    input  logic              ex_memren,
    input  logic              ex_memwen,
    input  logic [WORD_W-1:0] ex_store_data,
    output logic              mem_valid,
    output logic [WORD_W-1:0] mem_out,
    output logic              mem_negative,
    output logic              mem_zero,
    output logic [REG_W-1:0]  mem_wsel,
    output logic              mem_regwen,
    output logic              mem_memren,
    output logic              mem_memwen,
    output logic [WORD_W-1:0] mem_store_data,
    output logic              ovf_exception,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_wsel,
    output logic [WORD_W-1:0] fwd_data,
    output logic              load_pending,
    output logic [CNT_W-1:0]  captured_count
);

    // One latched instruction.
    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] out;
        logic              negative;
        logic              zero;
        logic [REG_W-1:0]  wsel;
        logic              regwen;
        logic              memren;
        logic              memwen;
        logic [WORD_W-1:0] store_data;
        logic              exc;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    stage_t           q;
    stage_t           nxt;
    logic             trap;
    logic             ctrl_ok;
    logic [CNT_W-1:0] count;

    // A trapping instruction keeps its slot in MEM (valid, data captured) but
    // loses every side effect; a bubble carries no controls whatever EX drives.
    assign trap    = ex_valid & ex_ovf_trap_en & ex_overflow;
    assign ctrl_ok = ex_valid & ~trap;

    always_comb begin
        nxt            = '0;
        nxt.valid      = ex_valid;
        nxt.out        = ex_out;
        nxt.negative   = ex_negative;
        nxt.zero       = ex_zero;
        nxt.wsel       = ex_wsel;
        nxt.regwen     = ex_regwen & ctrl_ok;
        nxt.memren     = ex_memren & ctrl_ok;
        nxt.memwen     = ex_memwen & ctrl_ok;
        nxt.store_data = ex_store_data;
        nxt.exc        = trap;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q     <= '0;
            count <= '0;
        end else if (flush) begin
            // Squash only the state that causes side effects; data fields
            // hold so the address of the killed instruction stays visible.
            q.valid  <= 1'b0;
            q.regwen <= 1'b0;
            q.memren <= 1'b0;
            q.memwen <= 1'b0;
            q.exc    <= 1'b0;
        end else if (en) begin
            q <= nxt;
            if (ex_valid) count <= count + CNT_ONE;
        end
    end

    assign mem_valid      = q.valid;
    assign mem_out        = q.out;
    assign mem_negative   = q.negative;
    assign mem_zero       = q.zero;
    assign mem_wsel       = q.wsel;
    assign mem_regwen     = q.regwen;
    assign mem_memren     = q.memren;
    assign mem_memwen     = q.memwen;
    assign mem_store_data = q.store_data;
    assign ovf_exception  = q.valid & q.exc;
    assign captured_count = count;

    // Forwarding view is purely from registers; $0 is never a producer.
    assign fwd_en       = q.valid & q.regwen & ~q.memren & (q.wsel != '0);
    assign fwd_wsel     = q.wsel;
    assign fwd_data     = q.out;
    assign load_pending = q.valid & q.regwen & q.memren & (q.wsel != '0);

endmodule
